// File: rtl/uart_byte_link.sv
// Byte-level 8N1 UART link between the disk device controller and the serial pins.
// Independent TX and RX FSMs; received bytes wait in a one-byte holding register until requested.
module uart_byte_link #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dev_enable,
    input  logic       dev_we,
    input  logic [7:0] dev_data_out,
    output logic [7:0] dev_data_in,
    output logic       dev_read_done,
    output logic       dev_write_done,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              wdone_q, wdone_d;

    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_meta_q, rx_sync_q;
    logic              ferr_q, ferr_d;
    logic              rx_ok;

    logic [7:0]        hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        din_q, din_d;
    logic              rdone_q, rdone_d;
    logic              ovr_q, ovr_d;
    logic              deliver;

    // TX FSM; the line level is registered from the next state so it changes with the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        wdone_d    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (dev_enable && dev_we) begin
                    tx_shift_d = dev_data_out;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    wdone_d    = 1'b1;
                    tx_state_d = TX_GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // RX FSM on the synchronized line; the stop bit is judged at its mid-point.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        ferr_d     = 1'b0;
        rx_ok      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_ok      = rx_sync_q;
                    ferr_d     = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Holding register and delivery; a delivery cycle is never followed directly by another.
    always_comb begin
        deliver      = dev_enable & ~dev_we & hold_valid_q & ~rdone_q;
        hold_d       = rx_ok ? rx_shift_q : hold_q;
        hold_valid_d = rx_ok | (hold_valid_q & ~deliver);
        ovr_d        = ovr_q | (rx_ok & hold_valid_q & ~deliver);
        din_d        = deliver ? hold_q : din_q;
        rdone_d      = deliver;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            wdone_q      <= 1'b0;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            ferr_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            din_q        <= '0;
            rdone_q      <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            wdone_q      <= wdone_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            ferr_q       <= ferr_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            din_q        <= din_d;
            rdone_q      <= rdone_d;
            ovr_q        <= ovr_d;
        end
    end

    assign uart_tx        = tx_q;
    assign dev_write_done = wdone_q;
    assign dev_read_done  = rdone_q;
    assign dev_data_in    = din_q;
    assign rx_overrun     = ovr_q;
    assign rx_frame_err   = ferr_q;
endmodule

// File: tb/tb_uart_byte_link.sv
// Directed bench for uart_byte_link at CLKS_PER_BIT = 8.
// Inputs change and outputs are sampled 1 time unit after the rising edge; events are logged on the falling edge.
module tb_uart_byte_link;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       dev_enable, dev_we;
    logic [7:0] dev_data_out;
    logic [7:0] dev_data_in;
    logic       dev_read_done, dev_write_done;
    logic       uart_rx, uart_tx;
    logic       rx_overrun, rx_frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0, rd_cyc = 0, fe_cnt = 0, rd_dbl = 0, wd_dbl = 0;
    logic [7:0] rd_data = 8'h00;
    logic rd_prev = 1'b0, wd_prev = 1'b0;

    uart_byte_link #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst),
        .dev_enable(dev_enable), .dev_we(dev_we), .dev_data_out(dev_data_out),
        .dev_data_in(dev_data_in), .dev_read_done(dev_read_done), .dev_write_done(dev_write_done),
        .uart_rx(uart_rx), .uart_tx(uart_tx),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dev_read_done) begin
            rd_cnt++;
            rd_data = dev_data_in;
            rd_cyc  = cyc;
        end
        if (rx_frame_err) fe_cnt++;
        if (dev_read_done && rd_prev) rd_dbl++;
        if (dev_write_done && wd_prev) wd_dbl++;
        rd_prev = dev_read_done;
        wd_prev = dev_write_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called in the first start-bit cycle; returns in the cycle where dev_write_done must be high.
    task automatic tx_watch(input string tag, input logic [7:0] d);
        logic [9:0] fr;
        int bad;
        fr  = {1'b1, d, 1'b0};
        bad = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (uart_tx !== fr[i / CPB] || dev_write_done !== 1'b0) bad++;
            step(1);
        end
        chk({tag, "_bits"}, bad, 0);
        chk({tag, "_wdone"}, dev_write_done, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = fr[b];
            step(CPB);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, rd0, fe0;
        rst = 1'b1; dev_enable = 1'b0; dev_we = 1'b0; dev_data_out = 8'h00; uart_rx = 1'b1;
        step(3);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_din", dev_data_in, 8'h00);
        chk("rst_rdone", dev_read_done, 1'b0);
        chk("rst_wdone", dev_write_done, 1'b0);
        chk("rst_ovr", rx_overrun, 1'b0);
        chk("rst_ferr", rx_frame_err, 1'b0);
        rst = 1'b0;
        step(2);

        // Single transmit; dev_enable drops mid-frame and the frame still completes.
        dev_enable = 1'b1; dev_we = 1'b1; dev_data_out = 8'hA5;
        chk("a5_idle_high", uart_tx, 1'b1);
        step(1);
        dev_enable = 1'b0;
        tx_watch("a5", 8'hA5);
        step(1);
        chk("a5_wdone_single", dev_write_done, 1'b0);
        step(3);

        // Back-to-back: data changes in the cycle after the first dev_write_done.
        dev_enable = 1'b1; dev_we = 1'b1; dev_data_out = 8'hC3;
        step(1);
        tx_watch("c3", 8'hC3);
        step(1);
        dev_data_out = 8'h3C;
        chk("b2b_gap_high", uart_tx, 1'b1);
        step(1);
        dev_enable = 1'b0;
        tx_watch("3c", 8'h3C);
        step(3);

        // Receive with the request already pending. Stop mid-sample lands 78 cycles after
        // the start bit is driven (2 sync + 1 detect + 3 to half bit + 72), hold_valid at 79,
        // dev_read_done at 80.
        dev_enable = 1'b1; dev_we = 1'b0;
        t0 = cyc; rd0 = rd_cnt;
        send_rx(8'hFF, 1'b1);
        step(6);
        chk("ff_rd_count", rd_cnt - rd0, 1);
        chk("ff_rd_lat", rd_cyc - t0, 80);
        chk("ff_rd_data", rd_data, 8'hFF);
        chk("ff_din", dev_data_in, 8'hFF);
        dev_enable = 1'b0;
        step(2);

        // Two frames with no request: overrun, newest byte kept.
        rd0 = rd_cnt;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        step(4);
        chk("ovr_set", rx_overrun, 1'b1);
        chk("ovr_no_rd", rd_cnt - rd0, 0);
        dev_enable = 1'b1; dev_we = 1'b0;
        step(1);
        dev_enable = 1'b0;
        chk("ovr_rd_pulse", dev_read_done, 1'b1);
        chk("ovr_data", dev_data_in, 8'h22);
        step(1);
        chk("ovr_rd_single", dev_read_done, 1'b0);
        step(4);

        // Reset while both directions are mid-frame.
        dev_enable = 1'b1; dev_we = 1'b1; dev_data_out = 8'hF0; uart_rx = 1'b0;
        step(1);
        dev_enable = 1'b0;
        step(29);
        rst = 1'b1; uart_rx = 1'b1;
        step(1);
        chk("mrst_tx", uart_tx, 1'b1);
        chk("mrst_rdone", dev_read_done, 1'b0);
        chk("mrst_wdone", dev_write_done, 1'b0);
        chk("mrst_din", dev_data_in, 8'h00);
        chk("mrst_ovr", rx_overrun, 1'b0);
        rst = 1'b0;
        step(10);
        dev_enable = 1'b1; dev_we = 1'b1; dev_data_out = 8'h5A;
        step(1);
        dev_enable = 1'b0;
        tx_watch("5a", 8'h5A);
        step(2);
        dev_enable = 1'b1; dev_we = 1'b0; rd0 = rd_cnt;
        send_rx(8'h5A, 1'b1);
        step(4);
        chk("5a_rd_count", rd_cnt - rd0, 1);
        chk("5a_din", dev_data_in, 8'h5A);
        dev_enable = 1'b0;
        step(4);

        // Request coincides with completion of the second frame (cycle t0+158).
        rd0 = rd_cnt; t0 = cyc;
        fork
            begin
                send_rx(8'h11, 1'b1);
                send_rx(8'h22, 1'b1);
            end
            begin
                step(158);
                dev_enable = 1'b1; dev_we = 1'b0;
                step(1);
                dev_enable = 1'b0;
            end
        join
        step(4);
        chk("sim_rd_count", rd_cnt - rd0, 1);
        chk("sim_rd_lat", rd_cyc - t0, 159);
        chk("sim_rd_data", rd_data, 8'h11);
        chk("sim_no_ovr", rx_overrun, 1'b0);
        dev_enable = 1'b1; dev_we = 1'b0;
        step(1);
        dev_enable = 1'b0;
        chk("sim_hold_rd", dev_read_done, 1'b1);
        chk("sim_hold_data", dev_data_in, 8'h22);
        step(4);

        // Start glitch of 2 cycles with a request pending: nothing delivered, no error.
        dev_enable = 1'b1; dev_we = 1'b0; rd0 = rd_cnt; fe0 = fe_cnt;
        uart_rx = 1'b0;
        step(2);
        uart_rx = 1'b1;
        step(20);
        chk("glitch_no_rd", rd_cnt - rd0, 0);
        chk("glitch_no_ferr", fe_cnt - fe0, 0);
        dev_enable = 1'b0;
        step(2);

        // Good byte held, then a frame with a 0 stop bit must not disturb it.
        send_rx(8'h77, 1'b1);
        fe0 = fe_cnt;
        send_rx(8'h99, 1'b0);
        step(20);
        chk("ferr_once", fe_cnt - fe0, 1);
        chk("ferr_no_ovr", rx_overrun, 1'b0);
        dev_enable = 1'b1; dev_we = 1'b0;
        step(1);
        dev_enable = 1'b0;
        chk("ferr_hold_rd", dev_read_done, 1'b1);
        chk("ferr_hold_data", dev_data_in, 8'h77);
        step(4);

        chk("rd_never_double", rd_dbl, 0);
        chk("wd_never_double", wd_dbl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
